// File: rtl/hazard_sched_pkg.sv
// Shared definitions for the hazard scheduler: forwarding encodings, FSM states
// and the shadow-pipeline entry layout.
package hazard_sched_pkg;

    // Register index width carried in the shadow entries.
    localparam int unsigned SHADOW_AW = 5;

    // Operand / store-data forwarding selects.
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_ALU  = 2'b10;
    localparam logic [1:0] FWD_MEM  = 2'b01;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StMemWait = 2'd2
    } hz_state_e;

    // Destination-register state tracked per downstream stage.
    typedef struct packed {
        logic                 valid;
        logic [SHADOW_AW-1:0] dest;
        logic                 regwrite;
        logic                 memtoreg;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '0;

endpackage

// File: rtl/hazard_sched_match.sv
// Producer-match comparator: true when a shadow entry will write the register a
// consumer reads. Register $0 never produces a value.
module hazard_match
    import hazard_sched_pkg::*;
(
    input  shadow_t              entry_i,
    input  logic [SHADOW_AW-1:0] src_i,
    input  logic                 uses_i,
    output logic                 match_o
);

    assign match_o = entry_i.valid && entry_i.regwrite && uses_i &&
                     (entry_i.dest != '0) && (entry_i.dest == src_i);

endmodule

// File: rtl/hazard_sched.sv
// Central hazard scheduler for the 5-stage MIPS pipeline. Tracks EX/MEM/WB
// destination state, raises stall/bubble/flush and registers forwarding selects.
// Optional load-use stall counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_store,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic              br_taken,
    input  logic              mem_busy,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        fwd_mem,
    output logic [CNT_W-1:0]  stall_cnt
);

    shadow_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    // Store-data tracking for the instruction currently in EX.
    logic              ex_store_q, ex_store_d;
    logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
    hz_state_e         state_q, state_d;
    logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, fwd_mem_q, fwd_mem_d;

    logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit, mem_st_hit;
    logic load_use;

    hazard_match u_match_ex_rs (
        .entry_i (ex_q),
        .src_i   (id_rs),
        .uses_i  (id_uses_rs),
        .match_o (ex_rs_hit)
    );

    hazard_match u_match_ex_rt (
        .entry_i (ex_q),
        .src_i   (id_rt),
        .uses_i  (id_uses_rt),
        .match_o (ex_rt_hit)
    );

    hazard_match u_match_mem_rs (
        .entry_i (mem_q),
        .src_i   (id_rs),
        .uses_i  (id_uses_rs),
        .match_o (mem_rs_hit)
    );

    hazard_match u_match_mem_rt (
        .entry_i (mem_q),
        .src_i   (id_rt),
        .uses_i  (id_uses_rt),
        .match_o (mem_rt_hit)
    );

    // Store in EX against the producer one stage ahead of it.
    hazard_match u_match_mem_st (
        .entry_i (mem_q),
        .src_i   (ex_rt_q),
        .uses_i  (ex_store_q),
        .match_o (mem_st_hit)
    );

    // A store whose data alone comes from the load is fixed up at MEM instead.
    assign load_use = id_valid && ex_q.memtoreg &&
                      (ex_rs_hit || (ex_rt_hit && !id_is_store));

    // Pipeline controls: reset > mem_busy > br_taken > load-use.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                stall = 1'b1;
            end else if (br_taken) begin
                flush = 1'b1;
            end else if (load_use) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        end
    end

    // FSM next state; leaving MEM_WAIT re-evaluates as RUN in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun, StMemWait: begin
                if (mem_busy) begin
                    state_d = StMemWait;
                end else if (!br_taken && load_use) begin
                    state_d = StLuStall;
                end else begin
                    state_d = StRun;
                end
            end
            StLuStall: state_d = mem_busy ? StMemWait : StRun;
            default:   state_d = StRun;
        endcase
    end

    // Shadow pipeline and forwarding selects advance together unless frozen.
    always_comb begin
        ex_d       = ex_q;
        mem_d      = mem_q;
        wb_d       = wb_q;
        ex_store_d = ex_store_q;
        ex_rt_d    = ex_rt_q;
        fwd_a_d    = fwd_a_q;
        fwd_b_d    = fwd_b_q;
        fwd_mem_d  = fwd_mem_q;
        if (!mem_busy) begin
            wb_d       = mem_q;
            mem_d      = ex_q;
            ex_rt_d    = id_rt;
            ex_d       = SHADOW_EMPTY;
            ex_store_d = 1'b0;
            fwd_a_d    = FWD_NONE;
            fwd_b_d    = FWD_NONE;
            if (id_valid && !flush && !bubble) begin
                ex_d       = '{valid: 1'b1, dest: id_dest, regwrite: id_regwrite,
                               memtoreg: id_memtoreg};
                ex_store_d = id_is_store && id_uses_rt;
                // Youngest producer wins.
                if (ex_rs_hit) begin
                    fwd_a_d = FWD_ALU;
                end else if (mem_rs_hit) begin
                    fwd_a_d = FWD_MEM;
                end
                if (ex_rt_hit) begin
                    fwd_b_d = FWD_ALU;
                end else if (mem_rt_hit) begin
                    fwd_b_d = FWD_MEM;
                end
            end
            // When the store reaches MEM its producer sits in WB.
            fwd_mem_d = FWD_NONE;
            if (mem_st_hit) begin
                fwd_mem_d = mem_q.memtoreg ? FWD_MEM : FWD_ALU;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= SHADOW_EMPTY;
            mem_q      <= SHADOW_EMPTY;
            wb_q       <= SHADOW_EMPTY;
            ex_store_q <= 1'b0;
            ex_rt_q    <= '0;
            state_q    <= StRun;
            fwd_a_q    <= FWD_NONE;
            fwd_b_q    <= FWD_NONE;
            fwd_mem_q  <= FWD_NONE;
        end else begin
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            wb_q       <= wb_d;
            ex_store_q <= ex_store_d;
            ex_rt_q    <= ex_rt_d;
            state_q    <= state_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            fwd_mem_q  <= fwd_mem_d;
        end
    end

    assign fwd_a   = fwd_a_q;
    assign fwd_b   = fwd_b_q;
    assign fwd_mem = fwd_mem_q;

    // WB entry is retired state only; nothing forwards from it directly.
    logic unused_wb;
    assign unused_wb = ^wb_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count each LU_STALL cycle, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == StLuStall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: directed pipeline scenarios followed by
// random instruction streams, checked against an instruction-level model.
module tb_hazard_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rs, id_uses_rt, id_is_store, id_regwrite, id_memtoreg;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        br_taken, mem_busy;
    logic        stall, bubble, flush;
    logic [1:0]  fwd_a, fwd_b, fwd_mem;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_sched #(.REG_AW(5), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_is_store (id_is_store),
        .id_dest     (id_dest),
        .id_regwrite (id_regwrite),
        .id_memtoreg (id_memtoreg),
        .br_taken    (br_taken),
        .mem_busy    (mem_busy),
        .stall       (stall),
        .bubble      (bubble),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .fwd_mem     (fwd_mem),
        .stall_cnt   (stall_cnt)
    );

    // Instruction as decoded in ID.
    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       st;
        logic [4:0] dest;
        logic       rw;
        logic       ld;
    } id_t;

    // Instruction as it travels down EX/MEM/WB.
    typedef struct packed {
        logic       v;
        logic [4:0] dest;
        logic       rw;
        logic       ld;
        logic       st;
        logic [4:0] rt;
    } ins_t;

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic        flush;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [1:0]  fm;
        logic [15:0] cnt;
    } exp_t;

    exp_t        expq[$];
    ins_t        pipe[$];   // [0] in EX, [1] in MEM, [2] in WB
    logic [1:0]  m_fa, m_fb, m_fm;
    logic [15:0] m_cnt;
    bit          m_pend;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(input ins_t p, input logic [4:0] r);
        return p.v && p.rw && (p.dest != 5'd0) && (p.dest == r);
    endfunction

    function automatic logic [1:0] pick(input logic use_it, input logic [4:0] r);
        if (use_it && writes(pipe[0], r)) return 2'b10;
        if (use_it && writes(pipe[1], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic id_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                               input logic urt, input logic st, input logic [4:0] dest,
                               input logic rw, input logic ld);
        id_t i;
        i.v = 1'b1; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt; i.st = st;
        i.dest = dest; i.rw = rw; i.ld = ld;
        return i;
    endfunction

    function automatic id_t alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        return mk(s, t, 1'b1, 1'b1, 1'b0, d, 1'b1, 1'b0);
    endfunction

    function automatic id_t lw(input logic [4:0] d, input logic [4:0] s);
        return mk(s, 5'd0, 1'b1, 1'b0, 1'b0, d, 1'b1, 1'b1);
    endfunction

    function automatic id_t sw(input logic [4:0] t, input logic [4:0] s);
        return mk(s, t, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    endfunction

    function automatic id_t nop();
        id_t i;
        i = '0;
        return i;
    endfunction

    function automatic id_t rnd_instr();
        logic [4:0]  a, b, d;
        int unsigned k;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 9);
        if (k < 4) return alu(d, a, b);
        if (k < 7) return lw(d, a);
        if (k < 9) return sw(b, a);
        return nop();
    endfunction

    task automatic model_reset();
        ins_t z;
        z = '0;
        pipe = {};
        for (int k = 0; k < 3; k++) pipe.push_back(z);
        m_fa = 2'b00; m_fb = 2'b00; m_fm = 2'b00;
        m_cnt = 16'd0; m_pend = 1'b0;
    endtask

    task automatic drive(input id_t i, input bit br, input bit busy);
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_uses_rs = i.urs; id_uses_rt = i.urt;
        id_is_store = i.st; id_dest = i.dest; id_regwrite = i.rw; id_memtoreg = i.ld;
        br_taken = br; mem_busy = busy;
    endtask

    // One pipeline cycle: drive ID, queue expectations, then advance the model.
    task automatic step(input id_t i, input bit br, input bit busy, output bit stalled);
        exp_t       e;
        bit         lu;
        logic [1:0] na, nb, nm;
        ins_t       nx;
        drive(i, br, busy);
        lu = i.v && pipe[0].ld && ((i.urs && writes(pipe[0], i.rs)) ||
                                   (i.urt && !i.st && writes(pipe[0], i.rt)));
        e.stall  = busy || (!br && lu);
        e.bubble = !busy && !br && lu;
        e.flush  = !busy && br;
        e.fa = m_fa; e.fb = m_fb; e.fm = m_fm; e.cnt = m_cnt;
        expq.push_back(e);
        stalled = e.stall;
        @(posedge clk);
        if (!busy) begin
            nx = '0;
            na = 2'b00;
            nb = 2'b00;
            if (i.v && !e.bubble && !e.flush) begin
                na = pick(i.urs, i.rs);
                nb = pick(i.urt, i.rt);
                nx.v = 1'b1; nx.dest = i.dest; nx.rw = i.rw; nx.ld = i.ld;
                nx.st = i.st && i.urt; nx.rt = i.rt;
            end
            nm = 2'b00;
            if (pipe[0].st && writes(pipe[1], pipe[0].rt)) nm = pipe[1].ld ? 2'b01 : 2'b10;
            m_fa = na; m_fb = nb; m_fm = nm;
            pipe.push_front(nx);
            void'(pipe.pop_back());
        end
`ifdef HAZ_PERF_CNT_EN
        if (m_pend && m_cnt != 16'hffff) m_cnt++;
        m_pend = e.bubble;
`endif
        #1;
    endtask

    // Monitor: every mid-cycle sample consumes one expected record.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall", 16'(stall), 16'(e.stall));
                chk("bubble", 16'(bubble), 16'(e.bubble));
                chk("flush", 16'(flush), 16'(e.flush));
                chk("fwd_a", 16'(fwd_a), 16'(e.fa));
                chk("fwd_b", 16'(fwd_b), 16'(e.fb));
                chk("fwd_mem", 16'(fwd_mem), 16'(e.fm));
`ifdef HAZ_PERF_CNT_EN
                chk("stall_cnt", stall_cnt, e.cnt);
`else
                chk("stall_cnt", stall_cnt, 16'd0);
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit  stl;
        bit  br, busy;
        id_t cur;
        rst_n = 1'b0;
        drive(nop(), 1'b1, 1'b1);
        model_reset();
        #12;
        chk("rst_stall", 16'(stall), 16'd0);
        chk("rst_bubble", 16'(bubble), 16'd0);
        chk("rst_flush", 16'(flush), 16'd0);
        chk("rst_fwd_a", 16'(fwd_a), 16'd0);
        chk("rst_fwd_b", 16'(fwd_b), 16'd0);
        chk("rst_fwd_mem", 16'(fwd_mem), 16'd0);
        chk("rst_cnt", stall_cnt, 16'd0);
        drive(nop(), 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // lw $5 ; add $6,$5,$1 (load-use, then MEM forwarding)
        step(lw(5'd5, 5'd2), 0, 0, stl);
        step(alu(5'd6, 5'd5, 5'd1), 0, 0, stl);
        step(alu(5'd6, 5'd5, 5'd1), 0, 0, stl);
        step(nop(), 0, 0, stl);
        step(nop(), 0, 0, stl);
        // add $5 ; sub $7,$5,$5 (EX forwarding on both operands)
        step(alu(5'd5, 5'd2, 5'd3), 0, 0, stl);
        step(alu(5'd7, 5'd5, 5'd5), 0, 0, stl);
        step(nop(), 0, 0, stl);
        step(nop(), 0, 0, stl);
        // lw $5 ; sw $5 and add $5 ; sw $5 (store-data forwarding)
        step(lw(5'd5, 5'd3), 0, 0, stl);
        step(sw(5'd5, 5'd2), 0, 0, stl);
        step(nop(), 0, 0, stl);
        step(nop(), 0, 0, stl);
        step(alu(5'd5, 5'd2, 5'd3), 0, 0, stl);
        step(sw(5'd5, 5'd2), 0, 0, stl);
        step(nop(), 0, 0, stl);
        step(nop(), 0, 0, stl);
        // $0 is never a producer
        step(alu(5'd0, 5'd1, 5'd2), 0, 0, stl);
        step(alu(5'd3, 5'd0, 5'd0), 0, 0, stl);
        step(nop(), 0, 0, stl);
        // load-use with a taken branch in the same cycle
        step(lw(5'd5, 5'd2), 0, 0, stl);
        step(alu(5'd6, 5'd5, 5'd1), 1, 0, stl);
        step(nop(), 0, 0, stl);
        // memory wait during the stall cycle
        step(lw(5'd5, 5'd2), 0, 0, stl);
        step(alu(5'd6, 5'd5, 5'd1), 0, 0, stl);
        for (int k = 0; k < 3; k++) step(alu(5'd6, 5'd5, 5'd1), 0, 1, stl);
        step(alu(5'd6, 5'd5, 5'd1), 0, 0, stl);
        step(nop(), 0, 0, stl);
        step(nop(), 0, 0, stl);
        // third load-use event
        step(lw(5'd4, 5'd1), 0, 0, stl);
        step(alu(5'd2, 5'd1, 5'd4), 0, 0, stl);
        step(alu(5'd2, 5'd1, 5'd4), 0, 0, stl);
        step(nop(), 0, 0, stl);
        step(nop(), 0, 0, stl);

        // random streams; ID is held while stalled
        cur = rnd_instr();
        for (int k = 0; k < 400; k++) begin
            br   = ($urandom_range(0, 9) == 0);
            busy = ($urandom_range(0, 6) == 0);
            step(cur, br, busy, stl);
            if (!stl) cur = rnd_instr();
        end

        // async reset while a load-use stall is being raised
        step(lw(5'd5, 5'd2), 0, 0, stl);
        drive(alu(5'd6, 5'd5, 5'd1), 1'b0, 1'b0);
        #1;
        chk("pre_rst_stall", 16'(stall), 16'd1);
        chk("pre_rst_bubble", 16'(bubble), 16'd1);
        mem_busy = 1'b1;
        br_taken = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 16'(stall), 16'd0);
        chk("mid_rst_bubble", 16'(bubble), 16'd0);
        chk("mid_rst_flush", 16'(flush), 16'd0);
        chk("mid_rst_fwd_a", 16'(fwd_a), 16'd0);
        chk("mid_rst_fwd_b", 16'(fwd_b), 16'd0);
        chk("mid_rst_fwd_mem", 16'(fwd_mem), 16'd0);
        chk("mid_rst_cnt", stall_cnt, 16'd0);
        @(posedge clk);
        @(negedge clk);
        drive(nop(), 1'b0, 1'b0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        cur = rnd_instr();
        for (int k = 0; k < 60; k++) begin
            br   = ($urandom_range(0, 9) == 0);
            busy = ($urandom_range(0, 6) == 0);
            step(cur, br, busy, stl);
            if (!stl) cur = rnd_instr();
        end

        for (int k = 0; k < 4 && expq.size() != 0; k++) @(negedge clk);
        #1;
        chk("drain", 16'(expq.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Central hazard scheduler for the 5-stage pipelined MIPS core (IF/ID/EX/MEM/WB).
- Keeps a shadow copy of destination-register state for the EX, MEM and WB stages.
- Detects load-use hazards and drives the stall/bubble controls, and generates the registered forwarding selects for the two EX operands and for MEM store data.
- Also sequences pipeline freezes during multi-cycle memory waits and squashes on taken branches.

Parameters:
- REG_AW, 5, register index width
- CNT_W, 16, perf counter width (used only with the optional feature)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_AW  ID source register rs
- id_rt  in  REG_AW  ID source register rt
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_is_store  in  1  instruction is sw (rt is store data only)
- id_dest  in  REG_AW  destination register
- id_regwrite  in  1  instruction writes the register file
- id_memtoreg  in  1  instruction is a load
- br_taken  in  1  taken branch resolved in EX
- mem_busy  in  1  data memory not ready; freezes the whole pipeline
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- flush  out  1  squash IF/ID and ID/EX
- fwd_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM ALU result, 01 MEM/WB value
- fwd_b  out  2  EX operand B select, same encoding
- fwd_mem  out  2  MEM store-data select: 01 WB read data, 10 WB ALU result, 00 none
- stall_cnt  out  CNT_W  load-use stall cycles (optional feature only)

Behaviour:
- Async reset clears all outputs to 0, all shadow entries to invalid, and the FSM to RUN.
- Shadow entry per stage EX/MEM/WB: {valid, dest, regwrite, memtoreg}. Advances EX→MEM→WB each non-frozen cycle.
- Producer match: the entry is valid, regwrite=1, dest≠0, and dest equals the consumer's register with the matching uses_* bit set.
- Load-use condition: id_valid, EX entry has memtoreg=1 and is a producer for rs or rt. Exception: id_is_store with only rt matching → no stall (the value is forwarded at MEM via fwd_mem).
- FSM states:
  - RUN: normal operation.
  - LU_STALL: exactly one cycle.
  - MEM_WAIT: pipeline frozen.
- FSM transitions:
  - RUN→MEM_WAIT when mem_busy.
  - RUN→LU_STALL when the load-use condition holds and br_taken=0.
  - LU_STALL→RUN next cycle, or →MEM_WAIT if mem_busy.
  - MEM_WAIT→RUN on the first cycle mem_busy=0, then re-evaluate.
- Outputs are combinational from state and inputs:
  - MEM_WAIT: stall=1, bubble=0, flush=0; shadow and fwd_* hold.
  - Load-use (in RUN): stall=1, bubble=1; EX shadow entry loads invalid.
  - br_taken (not busy): flush=1, stall=0, bubble=0; EX shadow entry loads invalid. br_taken has priority over load-use.
- Priority order: rst_n > mem_busy > br_taken > load-use > normal.
- fwd_a/fwd_b are registered when the ID instruction advances, so they are valid during its EX cycle:
  - 10 if the current EX entry is a matching producer; else 01 if the MEM entry matches; else 00.
  - Youngest producer wins.
  - On bubble or flush they load 00.
- fwd_mem is registered when a store advances from EX to MEM. If the MEM entry matches the store's rt: 01 if that entry has memtoreg=1, else 10; otherwise 00.
- Latency: forwarding selects appear one cycle after the decision; stall/bubble/flush have zero latency.
- rst_n asserted mid-stall or mid-wait returns to RUN with an empty shadow pipeline immediately.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - stall_cnt increments once per LU_STALL cycle, saturates at all-ones, and resets to 0.
  - MEM_WAIT cycles are not counted.
- HAZ_PERF_CNT_EN undefined: stall_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Shared package holds:
  - Forward encodings FWD_NONE=2'b00, FWD_ALU=2'b10, FWD_MEM=2'b01.
  - FSM state encoding (RUN, LU_STALL, MEM_WAIT).
  - Shadow-entry struct/field widths.
- One sub-module, hazard_match: combinational producer-match comparator, instantiated per stage/operand.

Test Plan:
- lw $5 followed by add $6,$5,$1 → stall=1, bubble=1 for exactly 1 cycle; then fwd_a=01 in the add's EX cycle.
- add $5,$2,$3 followed by sub $7,$5,$5 → no stall; fwd_a=10 and fwd_b=10 in the sub's EX cycle.
- lw $5 followed by sw $5,0($2) → no stall; fwd_mem=01 in the sw's MEM cycle. Repeat with add $5 as the producer → fwd_mem=10.
- add $0,$1,$2 followed by add $3,$0,$0 → fwd_a=fwd_b=00, no stall.
- Load-use with br_taken=1 in the same cycle → flush=1, stall=0, bubble=0. mem_busy held 3 cycles mid-stall → stall=1 for 3 cycles, fwd_* unchanged, FSM resumes RUN.
- rst_n pulled low during LU_STALL → all outputs 0 asynchronously. With HAZ_PERF_CNT_EN, 3 load-use events → stall_cnt=3.
